// File: rtl/if_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared definitions for the instruction-fetch queue slice:
//   - default address / instruction widths
//   - fetch FSM state encoding (RUN issues requests, DRAIN discards stale
//     responses after a redirect)
//   - ptr_width(): FIFO pointer width, one extra wrap bit over the index
// ---------------------------------------------------------------------------
package if_fetch_queue_pkg;

  localparam int AW_DEF = 32;
  localparam int IW_DEF = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  // Pointers carry one extra bit so full and empty can be told apart when the
  // index bits match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_sync_fifo.sv
// ---------------------------------------------------------------------------
// if_sync_fifo
// Small synchronous show-ahead FIFO. The head entry is visible on o_dout
// while the FIFO is non-empty and reads as zero when empty.
// Ports:
//   i_clk, i_srst     clock, synchronous active-high reset
//   i_push, i_din     write request and data (ignored when full unless a pop
//                     happens in the same cycle)
//   i_pop             remove head (ignored when empty)
//   i_clear           drop all entries at the next edge (wins over push/pop)
//   o_dout            head data, zero when empty
//   o_full, o_empty   status flags
//   o_count           number of stored entries
// ---------------------------------------------------------------------------
module if_sync_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                        i_clk,
  input  logic                        i_srst,
  input  logic                        i_push,
  input  logic [W-1:0]                i_din,
  input  logic                        i_pop,
  input  logic                        i_clear,
  output logic [W-1:0]                o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [ptr_width(DEPTH)-1:0] o_count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IX = PW - 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same index, different wrap bit: the writer is a full lap ahead.
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[IX-1:0] == r_rd_ptr[IX-1:0]);

  assign w_do_pop  = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr[IX-1:0]] <= i_din;
  end

  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr[IX-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch stage behind the PC register. Issues in-order fetch
// requests (req/gnt), pairs each response with the PC it was fetched from,
// queues the pairs and hands them to decode over valid/ready. A Flush
// (branch redirect) empties the queue and discards every in-flight response.
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   IF_Addr                  current PC
//   PC_En                    PC may advance (request accepted this cycle)
//   Flush                    redirect, drop all fetched / in-flight work
//   IM_Req, IM_Addr, IM_Gnt  fetch request handshake
//   IM_RValid, IM_RData      in-order fetch responses
//   ID_Valid, ID_Inst, ID_PC head of the queue to decode
//   ID_Ready                 decode consumes the head
// ---------------------------------------------------------------------------
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW-1:0] IF_Addr,
  output logic          PC_En,
  input  logic          Flush,
  output logic          IM_Req,
  output logic [AW-1:0] IM_Addr,
  input  logic          IM_Gnt,
  input  logic          IM_RValid,
  input  logic [IW-1:0] IM_RData,
  output logic          ID_Valid,
  output logic [IW-1:0] ID_Inst,
  output logic [AW-1:0] ID_PC,
  input  logic          ID_Ready
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] DEPTH_EXT = (PW+1)'(DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [PW-1:0] r_outstanding;
  logic [PW-1:0] w_outstanding_next;
  logic [PW-1:0] r_drop_cnt;
  logic [PW-1:0] w_drop_cnt_next;

  logic          w_rvalid;
  logic          w_accept;
  logic          w_space;
  logic [PW-1:0] w_remaining;
  logic [PW-1:0] w_occ;

  logic          w_q_push;
  logic          w_q_pop;
  logic          w_q_empty;
  logic [IW+AW-1:0] w_q_din;
  logic [IW+AW-1:0] w_q_dout;
  logic [AW-1:0] w_pend_pc;

  logic          w_unused_q_full;
  logic          w_unused_pend_full;
  logic          w_unused_pend_empty;
  logic [PW-1:0] w_unused_pend_count;

  // A response with nothing outstanding is a protocol error; ignore it.
  assign w_rvalid = IM_RValid & (r_outstanding != '0);

  // Requests in flight plus queued entries never exceed the queue capacity,
  // so every response is guaranteed a slot on arrival.
  assign w_space  = ({1'b0, r_outstanding} + {1'b0, w_occ}) < DEPTH_EXT;
  assign IM_Req   = ~Rst & (r_state == ST_RUN) & ~Flush & w_space;
  assign IM_Addr  = IF_Addr;
  assign w_accept = IM_Req & IM_Gnt;
  assign PC_En    = w_accept;

  // Requests still owed a response after this cycle's response retires.
  assign w_remaining = r_outstanding - PW'(w_rvalid);

  // -------------------------------------------------------------------------
  // Fetch FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_RUN;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_outstanding_next;
      r_drop_cnt    <= w_drop_cnt_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_drop_cnt_next    = r_drop_cnt;
    w_outstanding_next = r_outstanding + PW'(w_accept) - PW'(w_rvalid);

    case (r_state)
      ST_RUN: begin
        if (Flush && (w_remaining != '0)) begin
          w_state_next    = ST_DRAIN;
          w_drop_cnt_next = w_remaining;
        end
      end
      ST_DRAIN: begin
        if (Flush) begin
          // Re-arm from the true in-flight count rather than the old value.
          w_drop_cnt_next = w_remaining;
          w_state_next    = (w_remaining != '0) ? ST_DRAIN : ST_RUN;
        end else if (w_rvalid) begin
          w_drop_cnt_next = r_drop_cnt - 1'b1;
          if (r_drop_cnt == PW'(1)) w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next    = ST_RUN;
        w_drop_cnt_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Pending-PC FIFO: one entry per accepted request, popped by its response
  // (also while draining, so it stays aligned with memory).
  // -------------------------------------------------------------------------
  if_sync_fifo #(
    .W     (AW),
    .DEPTH (DEPTH)
  ) u_pend_fifo (
    .i_clk   (Clk),
    .i_srst  (Rst),
    .i_push  (w_accept),
    .i_din   (IF_Addr),
    .i_pop   (w_rvalid),
    .i_clear (1'b0),
    .o_dout  (w_pend_pc),
    .o_full  (w_unused_pend_full),
    .o_empty (w_unused_pend_empty),
    .o_count (w_unused_pend_count)
  );

  // -------------------------------------------------------------------------
  // Instruction queue: {PC, instruction}. Responses arriving while draining
  // or in a Flush cycle belong to the abandoned path and are not written.
  // -------------------------------------------------------------------------
  assign w_q_push = w_rvalid & (r_state == ST_RUN) & ~Flush;
  assign w_q_pop  = ID_Valid & ID_Ready;
  assign w_q_din  = {w_pend_pc, IM_RData};

  if_sync_fifo #(
    .W     (IW + AW),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .i_clk   (Clk),
    .i_srst  (Rst),
    .i_push  (w_q_push),
    .i_din   (w_q_din),
    .i_pop   (w_q_pop),
    .i_clear (Flush),
    .o_dout  (w_q_dout),
    .o_full  (w_unused_q_full),
    .o_empty (w_q_empty),
    .o_count (w_occ)
  );

  assign ID_Valid = ~w_q_empty;
  assign ID_Inst  = w_q_dout[IW-1:0];
  assign ID_PC    = w_q_dout[IW+AW-1:IW];

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Drives the fetch queue with a behavioural PC register and instruction
// memory. Every accepted request is tagged with the redirect epoch it was
// issued in; responses from an older epoch are expected to be dropped.
// Responses that survive are pushed to an expected queue and compared when
// decode consumes them.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int IW    = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] IF_Addr;
  logic          PC_En;
  logic          Flush;
  logic          IM_Req;
  logic [AW-1:0] IM_Addr;
  logic          IM_Gnt;
  logic          IM_RValid;
  logic [IW-1:0] IM_RData;
  logic          ID_Valid;
  logic [IW-1:0] ID_Inst;
  logic [AW-1:0] ID_PC;
  logic          ID_Ready;

  if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .IF_Addr   (IF_Addr),
    .PC_En     (PC_En),
    .Flush     (Flush),
    .IM_Req    (IM_Req),
    .IM_Addr   (IM_Addr),
    .IM_Gnt    (IM_Gnt),
    .IM_RValid (IM_RValid),
    .IM_RData  (IM_RData),
    .ID_Valid  (ID_Valid),
    .ID_Inst   (ID_Inst),
    .ID_PC     (ID_PC),
    .ID_Ready  (ID_Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
    int            t_acc;
  } req_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  req_t          mem_q[$];
  ent_t          exp_q[$];
  int            epoch = 0;
  int            cyc   = 0;
  int            lat   = 1;
  logic [AW-1:0] pc    = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs and state
  // against the model, then advance the model across the edge.
  task automatic step(input bit flush, input bit gnt, input bit ready,
                      input bit resp_en, input logic [AW-1:0] new_pc);
    bit   resp;
    bit   exp_req;
    int   n_old;
    req_t r;
    ent_t e;

    resp = resp_en && (mem_q.size() > 0) && (cyc >= mem_q[0].t_acc + lat);
    Flush     = flush;
    IM_Gnt    = gnt;
    ID_Ready  = ready;
    IF_Addr   = pc;
    IM_RValid = resp;
    IM_RData  = resp ? inst_of(mem_q[0].addr) : IW'($urandom);
    #2;

    n_old = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) n_old++;
    exp_req = !flush && (n_old == 0) && (mem_q.size() + exp_q.size() < DEPTH);

    check_val("state", 64'(u_dut.r_state), 64'((n_old > 0) ? ST_DRAIN : ST_RUN));
    if (n_old > 0) check_val("drop_cnt", 64'(u_dut.r_drop_cnt), 64'(n_old));
    check_val("im_req", 64'(IM_Req), 64'(exp_req));
    check_val("pc_en", 64'(PC_En), 64'(exp_req && gnt));
    if (exp_req) check_val("im_addr", 64'(IM_Addr), 64'(pc));
    check_val("id_valid", 64'(ID_Valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_val("id_pc", 64'(ID_PC), 64'(exp_q[0].pc));
      check_val("id_inst", 64'(ID_Inst), 64'(exp_q[0].inst));
    end else begin
      check_val("id_pc_zero", 64'(ID_PC), 64'h0);
      check_val("id_inst_zero", 64'(ID_Inst), 64'h0);
    end

    // Model update for the coming edge.
    if (!flush && ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("cyc %0d deq pc=%08h inst=%08h", cyc, e.pc, e.inst);
    end
    if (resp) begin
      assert (mem_q.size() > 0);
      r = mem_q.pop_front();
      if (!flush && r.epoch == epoch) exp_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
      else $display("cyc %0d drop pc=%08h", cyc, r.addr);
    end
    if (exp_req && gnt) begin
      mem_q.push_back('{addr: pc, epoch: epoch, t_acc: cyc});
      $display("cyc %0d req pc=%08h", cyc, pc);
      pc = pc + 4;
    end
    if (flush) begin
      exp_q.delete();
      epoch++;
      pc = new_pc;
      $display("cyc %0d flush -> pc=%08h", cyc, new_pc);
    end

    @(posedge Clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    Rst = 1'b1;
    Flush = 1'b0;
    IM_Gnt = 1'b1;
    IM_RValid = 1'b0;
    IM_RData = '0;
    ID_Ready = 1'b0;
    IF_Addr = '0;
    for (int i = 0; i < cycles; i++) begin
      #2;
      check_val("rst_im_req", 64'(IM_Req), 64'h0);
      check_val("rst_pc_en", 64'(PC_En), 64'h0);
      @(posedge Clk);
      cyc++;
      #1;
    end
    Rst = 1'b0;
    mem_q.delete();
    exp_q.delete();
    pc = '0;
    $display("cyc %0d reset released", cyc);
  endtask

  initial begin
    int guard;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    do_reset(2);

    // Steady stream, 1-cycle latency, decode always ready.
    lat = 1;
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1, '0);

    // Backpressure: decode stalls, queue fills, requests stop.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, '0);

    // Grant stall.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, '0);

    // Empty everything, then flush with two requests in flight.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, '0);
    lat = 4;
    for (int i = 0; i < 2; i++) step(0, 1, 1, 1, '0);
    step(1, 1, 1, 1, 32'h40);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1, '0);

    // Flush coincident with the single outstanding response.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, '0);
    lat = 1;
    step(0, 1, 1, 1, '0);
    step(1, 1, 1, 1, 32'h100);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, '0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, '0);
    lat = 5;
    for (int i = 0; i < 2; i++) step(0, 1, 1, 1, '0);
    step(1, 1, 1, 1, 32'h200);
    step(0, 1, 1, 1, '0);
    do_reset(1);
    lat = 1;
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, '0);

    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 60; i++) begin
      if ((i % 15) == 0) lat = $urandom_range(1, 3);
      step(($urandom_range(0, 11) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) != 0), {20'h0, 6'($urandom_range(0, 63)), 6'h0});
    end

    // Bounded drain of everything still in flight or queued.
    guard = 0;
    while ((exp_q.size() > 0 || mem_q.size() > 0) && guard < 50) begin
      step(0, 0, 1, 1, '0);
      guard++;
    end
    check_val("drain_timeout", 64'(exp_q.size() + mem_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
